// File: rtl/psc_trigger_pkg.sv
// Shared definitions for the PSC trigger scheduler: FSM state encoding,
// default hold-off length and the width helper used for channel indices.
package psc_trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_FIRE  = 2'd2,
      ST_HOLD  = 2'd3
   } schedState_e;

   localparam int HOLDOFF_DEFAULT = 100;

   // Number of bits needed to index 'value' entries, never less than one
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width = width + 1;
      return width;
   endfunction

endpackage

// File: rtl/psc_rr_arbiter.sv
// Combinational round-robin search: picks the first pending channel
// after last_grant, wrapping around, so every channel gets its turn.
module psc_rr_arbiter
   import psc_trigger_pkg::*;
#(
   parameter  int N_CH = 4,
   localparam int CH_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0] pending,
   input  logic [CH_W-1:0] last_grant,
   output logic            grant_valid,
   output logic [CH_W-1:0] grant_idx
);

   logic [CH_W-1:0] candIdx;

   // Walk offsets from farthest to nearest so the nearest pending channel is the last (winning) assignment
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      candIdx     = '0;
      for (int k = N_CH; k >= 1; k--) begin
         candIdx = CH_W'((int'(last_grant) + k) % N_CH);
         if (pending[candIdx]) begin
            grant_valid = 1'b1;
            grant_idx   = candIdx;
         end
      end
   end

endmodule

// File: rtl/psc_trigger_sched.sv
// Round-robin trigger scheduler in front of the PSC trigger transmitter.
// Latches channel requests, grants one at a time, waits the channel's
// programmed delay, fires one start pulse and then holds off the link.
module psc_trigger_sched
   import psc_trigger_pkg::*;
#(
   parameter  int N_CH    = 4,
   parameter  int DLY_W   = 16,
   parameter  int HOLDOFF = HOLDOFF_DEFAULT,
   localparam int CH_W    = clog2(N_CH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  trig_in,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_addr,
   input  logic [DLY_W-1:0] cfg_delay,
   output logic             tx_start,
   output logic [CH_W-1:0]  tx_chan,
   input  logic             tx_busy,
   output logic [N_CH-1:0]  pending,
   output logic [N_CH-1:0]  overrun,
   input  logic             clear_ovr,
   output logic             active
);

   // The shared counter must hold both a full delay value and HOLDOFF-1
   localparam int HO_W  = clog2(HOLDOFF);
   localparam int CNT_W = (DLY_W > HO_W) ? DLY_W : HO_W;

   schedState_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]  txChan_q, txChan_d;
   logic [CH_W-1:0]  lastGrant_q, lastGrant_d;
   logic [N_CH-1:0]  trigDelay_q;
   logic [N_CH-1:0]  pending_q, pending_d;
   logic [N_CH-1:0]  overrun_q, overrun_d;
   logic [N_CH-1:0]  rise;
   logic [N_CH-1:0]  grantMask;
   logic [DLY_W-1:0] delayTable_q [N_CH];
   logic             grantValid;
   logic [CH_W-1:0]  grantIdx;
   logic             grantNow;

   assign rise     = trig_in & ~trigDelay_q;
   assign pending  = pending_q;
   assign overrun  = overrun_q;
   assign tx_chan  = txChan_q;
   assign active   = (state_q != ST_IDLE);

   psc_rr_arbiter #(
      .N_CH(N_CH)
   ) uArbiter (
      .pending     (pending_q),
      .last_grant  (lastGrant_q),
      .grant_valid (grantValid),
      .grant_idx   (grantIdx)
   );

   // Previous trigger level; loading it during reset too means a level held across release is not an edge
   always_ff @(posedge clk) begin
      trigDelay_q <= trig_in;
   end

   // Delay table: only an exactly matching in-range index is written
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) delayTable_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (cfg_we && (cfg_addr == CH_W'(i))) delayTable_q[i] <= cfg_delay;
         end
      end
   end

   // Pending and overrun flags; a new edge beats both the grant-clear and clear_ovr
   always_comb begin
      grantMask = '0;
      if (grantNow) grantMask = N_CH'(1) << grantIdx;
      pending_d = (pending_q & ~grantMask) | rise;
      overrun_d = overrun_q;
      if (clear_ovr) overrun_d = '0;
      overrun_d = overrun_d | (rise & pending_q & ~grantMask);
   end

   // Flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   // Scheduler next-state: grant, count down the delay, fire once, then hold off
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      txChan_d    = txChan_q;
      lastGrant_d = lastGrant_q;
      grantNow    = 1'b0;
      tx_start    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grantValid) begin
               grantNow    = 1'b1;
               txChan_d    = grantIdx;
               lastGrant_d = grantIdx;
               cnt_d       = CNT_W'(delayTable_q[grantIdx]);
               state_d     = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (cnt_q == '0) state_d = ST_FIRE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_FIRE: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               cnt_d    = CNT_W'(HOLDOFF - 1);
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
            else if (!tx_busy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Scheduler registers; last grant starts at the top channel so channel 0 is served first
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         txChan_q    <= '0;
         lastGrant_q <= CH_W'(N_CH - 1);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         txChan_q    <= txChan_d;
         lastGrant_q <= lastGrant_d;
      end
   end

endmodule

// File: tb/tb_psc_trigger_sched.sv
// Testbench for psc_trigger_sched: directed stimulus pushes the expected
// start pulses (cycle and channel) into a queue, a monitor pops and checks.
module tb_psc_trigger_sched;

   localparam int N_CH    = 4;
   localparam int DLY_W   = 16;
   localparam int HOLDOFF = 100;
   localparam int CH_W    = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_CH-1:0]  trig_in;
   logic             cfg_we;
   logic [CH_W-1:0]  cfg_addr;
   logic [DLY_W-1:0] cfg_delay;
   logic             tx_start;
   logic [CH_W-1:0]  tx_chan;
   logic             tx_busy;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  overrun;
   logic             clear_ovr;
   logic             active;

   typedef struct {
      int cyc;
      int chan;
   } expect_t;

   expect_t sbQueue[$];
   int      errors = 0;
   int      checks = 0;
   int      cyc    = 0;
   int      t;

   psc_trigger_sched #(
      .N_CH(N_CH),
      .DLY_W(DLY_W),
      .HOLDOFF(HOLDOFF)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .trig_in   (trig_in),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_delay (cfg_delay),
      .tx_start  (tx_start),
      .tx_chan   (tx_chan),
      .tx_busy   (tx_busy),
      .pending   (pending),
      .overrun   (overrun),
      .clear_ovr (clear_ovr),
      .active    (active)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle number; constant between rising edges
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every start pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (tx_start) begin
         if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedStart: tx_start at cycle %0d chan %0d, required no pulse", cyc, tx_chan);
         end else begin
            expect_t e;
            e = sbQueue.pop_front();
            checks++;
            if (cyc != e.cyc) begin
               errors++;
               $display("[TB] FAIL startCycle: got cycle %0d, required %0d", cyc, e.cyc);
            end
            checks++;
            if (int'(tx_chan) != e.chan) begin
               errors++;
               $display("[TB] FAIL startChan: got %0d, required %0d", tx_chan, e.chan);
            end
         end
      end
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N_CH-1:0] trig, input int cycles);
      trig_in = trig;
      tick(cycles);
   endtask

   task automatic cfgWrite(input logic [CH_W-1:0] addr, input logic [DLY_W-1:0] value);
      cfg_we    = 1'b1;
      cfg_addr  = addr;
      cfg_delay = value;
      tick(1);
      cfg_we    = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int n;
      n = 0;
      while ((sbQueue.size() != 0 || active) && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (sbQueue.size() != 0 || active) begin
         errors++;
         $display("[TB] FAIL %s: still %0d pulses outstanding, active=%0b after %0d cycles, required idle", name, sbQueue.size(), active, budget);
      end
   endtask

   // Directed sequence
   initial begin
      reset     = 1'b1;
      trig_in   = '0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_delay = '0;
      tx_busy   = 1'b0;
      clear_ovr = 1'b0;
      tick(3);
      reset = 1'b0;

      // Reset state
      checkOutput("rstTxStart", tx_start, 0);
      checkOutput("rstTxChan",  tx_chan,  0);
      checkOutput("rstPending", pending,  0);
      checkOutput("rstOverrun", overrun,  0);
      checkOutput("rstActive",  active,   0);

      // Single channel with delay 10: pulse at t+13
      cfgWrite(0, 10);
      t = cyc;
      sbQueue.push_back('{t + 13, 0});
      applyStimulus(4'b0001, 1);
      checkOutput("t1PendingSet", pending, 4'b0001);
      tick(1);
      checkOutput("t1PendingClr", pending, 4'b0000);
      checkOutput("t1Active", active, 1);
      tick(3);
      trig_in = '0;
      waitDone("t1Done", 400);
      checkOutput("t1Overrun", overrun, 0);
      cfgWrite(0, 0);

      // Two simultaneous requests, zero delay: ch1 at t+3, ch3 one hold-off later
      t = cyc;
      sbQueue.push_back('{t + 3, 1});
      sbQueue.push_back('{t + 3 + HOLDOFF + 3, 3});
      applyStimulus(4'b1010, 1);
      checkOutput("t2PendingBoth", pending, 4'b1010);
      tick(1);
      checkOutput("t2PendingCh3", pending, 4'b1000);
      tick(2);
      trig_in = '0;
      waitDone("t2Done", 500);

      // Double request on ch2 during a 50-cycle ch0 delay
      cfgWrite(0, 50);
      t = cyc;
      sbQueue.push_back('{t + 53, 0});
      sbQueue.push_back('{t + 53 + HOLDOFF + 3, 2});
      applyStimulus(4'b0001, 5);
      applyStimulus(4'b0101, 1);
      applyStimulus(4'b0001, 1);
      applyStimulus(4'b0101, 1);
      trig_in = 4'b0001;
      checkOutput("t3OverrunSet", overrun, 4'b0100);
      checkOutput("t3Pending", pending, 4'b0100);
      tick(1);
      trig_in = '0;
      waitDone("t3Done", 500);
      checkOutput("t3OverrunSticky", overrun, 4'b0100);
      clear_ovr = 1'b1;
      tick(1);
      clear_ovr = 1'b0;
      checkOutput("t3OverrunClr", overrun, 0);
      cfgWrite(0, 0);

      // Transmitter busy when FIRE is reached; pulse only once busy drops
      tx_busy = 1'b1;
      t = cyc;
      sbQueue.push_back('{t + 20, 1});
      applyStimulus(4'b0010, 1);
      applyStimulus(4'b0000, 9);
      checkOutput("t4ActiveWait", active, 1);
      checkOutput("t4NoStart", tx_start, 0);
      tick(10);
      tx_busy = 1'b0;
      waitDone("t4Done", 400);

      // Reset during DELAY with ch0 and ch2 pending
      cfgWrite(1, 30);
      applyStimulus(4'b0010, 3);
      applyStimulus(4'b0111, 1);
      checkOutput("t5PendingQueued", pending, 4'b0101);
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checkOutput("t5PendingRst", pending, 0);
      checkOutput("t5ActiveRst", active, 0);
      checkOutput("t5TxStartRst", tx_start, 0);
      tick(150);
      checkOutput("t5PendingHeld", pending, 0);
      checkOutput("t5ActiveHeld", active, 0);
      trig_in = '0;
      tick(2);

      // Delay rewritten while counting: current fire keeps 5, next request uses 40
      cfgWrite(1, 5);
      t = cyc;
      sbQueue.push_back('{t + 8, 1});
      applyStimulus(4'b0010, 1);
      applyStimulus(4'b0000, 2);
      cfgWrite(1, 40);
      tick(16);
      sbQueue.push_back('{t + 8 + HOLDOFF + 43, 1});
      applyStimulus(4'b0010, 1);
      trig_in = '0;
      checkOutput("t6PendingAgain", pending, 4'b0010);
      waitDone("t6Done", 500);

      checkOutput("finalQueueEmpty", sbQueue.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
